// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } jk_state_e;

  localparam int JK_DC_HOLD   = 0;
  localparam int JK_DC_TOGGLE = 1;

  localparam int ERR_W = 16;

endpackage

// File: rtl/jk_excite_enc.sv
// Combinational JK excitation: J/K that move each flip-flop from cur to nxt.
module jk_excite_enc
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DC_POLICY = JK_DC_HOLD
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] j_next,
  output logic [WIDTH-1:0] k_next
);

  // Don't-care inputs resolved to 0 (hold) or to 1 (toggle).
  always_comb begin
    j_next = {WIDTH{1'b0}};
    k_next = {WIDTH{1'b0}};
    if (DC_POLICY == JK_DC_TOGGLE) begin
      j_next = cur | nxt;
      k_next = ~(cur & nxt);
    end else begin
      j_next = ~cur & nxt;
      k_next = cur & ~nxt;
    end
  end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a JK flip-flop bank toward a stream of target words, verifying Q
// feedback after each update and counting mismatches.
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DC_POLICY = JK_DC_HOLD,
  parameter int CHECK_EN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  jk_state_e        state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] j_enc_s, k_enc_s;

  jk_excite_enc #(
    .WIDTH     (WIDTH),
    .DC_POLICY (DC_POLICY)
  ) u_enc (
    .cur    (shadow_q),
    .nxt    (tgt_data),
    .j_next (j_enc_s),
    .k_next (k_enc_s)
  );

  assign tgt_ready = (state_q == ST_IDLE);
  assign busy      = ~tgt_ready;
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_cnt_q;

  // Next-state logic; j/k default to zero so the bank holds outside DRIVE.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    shadow_d   = shadow_q;
    j_d        = {WIDTH{1'b0}};
    k_d        = {WIDTH{1'b0}};
    done_d     = 1'b0;
    mismatch_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (tgt_valid) begin
          tgt_d   = tgt_data;
          j_d     = j_enc_s;
          k_d     = k_enc_s;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        // On a mismatch, trust the bank rather than the intended target.
        if ((CHECK_EN != 0) && (q_fb != tgt_q)) begin
          mismatch_d = 1'b1;
          shadow_d   = q_fb;
          if (err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end else begin
          shadow_d = tgt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tgt_q      <= {WIDTH{1'b0}};
      shadow_q   <= {WIDTH{1'b0}};
      j_q        <= {WIDTH{1'b0}};
      k_q        <= {WIDTH{1'b0}};
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= {ERR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      shadow_q   <= shadow_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule
